lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the execute/memory stage.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Drives a req/gnt/rvalid data-memory port, then returns aligned, sign/zero-extended load data to writeback.
- Multi-cycle; asserts busy so the pipeline stalls while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 16, watchdog limit in cycles per memory phase (used only with LSU_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  memory op present from execute
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code
- alu_result  in  32  effective address
- store_data  in  32  rs2 value
- req_rd  in  5  load destination register
- busy  out  1  access in flight (pipeline stall)
- dmem_req  out  1  memory request
- dmem_we  out  1  memory write
- dmem_addr  out  32  word-aligned address
- dmem_wstrb  out  4  byte write strobes
- dmem_wdata  out  32  lane-replicated write data
- dmem_gnt  in  1  request granted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- done  out  1  one-cycle completion pulse
- rd_we  out  1  writeback enable (pulse)
- rd_addr  out  5  writeback register
- rd_data  out  32  extended load data
- misalign  out  1  one-cycle misaligned/illegal-access pulse
- bus_err  out  1  one-cycle timeout pulse (tied 0 without LSU_TIMEOUT_EN)

Behaviour:
- Interface clock/reset: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values: state IDLE; all outputs 0 except req_ready=1; internal registers cleared.
- FSM states: IDLE, REQ, WAIT.
- req_ready = (state==IDLE); busy = !req_ready.
- IDLE, req_valid=1: latch address, we, funct3, rd, store_data.
  - If aligned and legal: go to REQ.
  - Otherwise: misalign=1 and done=1 next cycle, no memory access, rd_we=0, stay IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and handled as misaligned.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- REQ: dmem_req=1, dmem_addr={addr[31:2],2'b00}. Address, we, wstrb and wdata are held stable until dmem_gnt.
  - On the gnt cycle: a store goes to IDLE, with done=1 next cycle and rd_we=0.
  - On the gnt cycle: a load goes to WAIT.
  - dmem_req drops the cycle after gnt.
- Store data:
  - SB: byte replicated to all 4 lanes, wstrb=4'b0001<<addr[1:0].
  - SH: half replicated to both halves, wstrb 0011 or 1100.
  - SW: wstrb 1111.
  - Loads: wstrb=0.
- WAIT: rvalid is accepted only in WAIT (earliest the cycle after gnt).
  - On rvalid: shift rdata right by 8*addr[1:0], extend per funct3, register into rd_data.
  - The next cycle asserts done=1 and rd_we=(rd!=0), with rd_addr=latched rd. Go to IDLE.
- Loads to x0 still access memory; rd_we=0.
- Outputs are registered.
- Minimum latency, accept to done: store 2 cycles (gnt in the first REQ cycle); load 3 cycles.
- req_ready=1 in the cycle done pulses, so back-to-back accesses are allowed.
- rd_data, rd_addr, rd_we, misalign and bus_err are valid only while done=1.
- Reset mid-access: state returns to IDLE immediately. A later stray gnt/rvalid is ignored in IDLE.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: a counter clears on entering REQ or WAIT and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES without gnt (REQ) or rvalid (WAIT): abort to IDLE, pulse done=1 and bus_err=1 next cycle, rd_we=0.
  - gnt or rvalid arriving on the terminal count wins over the timeout.
- Not defined: no counter, bus_err tied 0, LSU waits indefinitely.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, gnt immediate -> dmem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF; done 2 cycles after accept, rd_we=0.
- SB addr 0x203, data 0x000000A5 -> dmem_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x302, rdata 0x12805634, rd=5 -> rd_data 0xFFFFFF80, rd_we=1, rd_addr=5.
- LHU addr 0x302 with the same rdata -> rd_data 0x00001280.
- LW addr 0x401 -> misalign=1 and done=1 next cycle, dmem_req never asserted.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> request held stable throughout.
- Same delayed LW with rst_n low in WAIT -> immediate IDLE, req_ready=1, no done.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never arrives -> bus_err and done pulse, rd_we=0, req_ready returns 1.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: RV32I loads/stores over a req/gnt/rvalid data-memory port.
// Optional watchdog per memory phase enabled by the LSU_TIMEOUT_EN macro.
module lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  req_rd,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [1:0]  off_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic        legal_s, tmo_s;
  logic        accept_ok_s, accept_bad_s, store_done_s, load_done_s, abort_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s, shifted_s, ext_s;
  logic        req_ready_r, busy_r, dmem_req_r, dmem_we_r, done_r, rd_we_r;
  logic        misalign_r, bus_err_r;
  logic [31:0] dmem_addr_r, dmem_wdata_r, rd_data_r;
  logic [3:0]  dmem_wstrb_r;
  logic [4:0]  rd_addr_r;

  // Request legality: funct3 must be a known width and the address naturally aligned.
  always_comb begin
    legal_s = 1'b0;
    case (req_funct3)
      3'b000:  legal_s = 1'b1;
      3'b001:  legal_s = (alu_result[0] == 1'b0);
      3'b010:  legal_s = (alu_result[1:0] == 2'b00);
      3'b100:  legal_s = !req_we;
      3'b101:  legal_s = !req_we && (alu_result[0] == 1'b0);
      default: legal_s = 1'b0;
    endcase
  end

  // Store lane steering: replicate the datum across lanes, strobe only the addressed bytes.
  always_comb begin
    wstrb_s = 4'b0000;
    wdata_s = store_data;
    case (req_funct3[1:0])
      2'b00: begin
        wstrb_s = 4'b0001 << alu_result[1:0];
        wdata_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_s = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{store_data[15:0]}};
      end
      2'b10: begin
        wstrb_s = 4'b1111;
        wdata_s = store_data;
      end
      default: begin
        wstrb_s = 4'b0000;
        wdata_s = store_data;
      end
    endcase
  end

  assign shifted_s = dmem_rdata >> {off_r, 3'b000};

  // Load extension of the lane-shifted read word.
  always_comb begin
    ext_s = 32'h0000_0000;
    case (funct3_r)
      3'b000:  ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  ext_s = shifted_s;
      3'b100:  ext_s = {24'h00_0000, shifted_s[7:0]};
      3'b101:  ext_s = {16'h0000, shifted_s[15:0]};
      default: ext_s = 32'h0000_0000;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_r;

  assign tmo_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // Phase watchdog: restarts on every state change, counts while in REQ or WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if ((state_r == IDLE) || (state_s != state_r)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
`else
  // Without the watchdog the unit waits indefinitely; the comparison is constant false.
  assign tmo_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state logic and single-cycle event decode.
  always_comb begin
    state_s      = state_r;
    accept_ok_s  = 1'b0;
    accept_bad_s = 1'b0;
    store_done_s = 1'b0;
    load_done_s  = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (legal_s) begin
            state_s     = REQ;
            accept_ok_s = 1'b1;
          end else begin
            state_s      = IDLE;
            accept_bad_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          state_s      = we_r ? IDLE : WAIT;
          store_done_s = we_r;
        end else if (tmo_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_s     = IDLE;
          load_done_s = 1'b1;
        end else if (tmo_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r        <= 2'b00;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      rd_r         <= 5'd0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'h0000_0000;
      dmem_wstrb_r <= 4'b0000;
      dmem_wdata_r <= 32'h0000_0000;
      done_r       <= 1'b0;
      rd_we_r      <= 1'b0;
      rd_addr_r    <= 5'd0;
      rd_data_r    <= 32'h0000_0000;
      misalign_r   <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      if ((state_r == IDLE) && req_valid) begin
        off_r    <= alu_result[1:0];
        we_r     <= req_we;
        funct3_r <= req_funct3;
        rd_r     <= req_rd;
      end
      if (accept_ok_s) begin
        dmem_req_r   <= 1'b1;
        dmem_we_r    <= req_we;
        dmem_addr_r  <= {alu_result[31:2], 2'b00};
        dmem_wstrb_r <= req_we ? wstrb_s : 4'b0000;
        dmem_wdata_r <= wdata_s;
      end else if ((state_r == REQ) && (state_s != REQ)) begin
        dmem_req_r   <= 1'b0;
        dmem_we_r    <= 1'b0;
        dmem_wstrb_r <= 4'b0000;
      end
      if (load_done_s) begin
        rd_data_r <= ext_s;
        rd_addr_r <= rd_r;
      end
      req_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= accept_bad_s | store_done_s | load_done_s | abort_s;
      rd_we_r     <= load_done_s && (rd_r != 5'd0);
      misalign_r  <= accept_bad_s;
      bus_err_r   <= abort_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wstrb = dmem_wstrb_r;
  assign dmem_wdata = dmem_wdata_r;
  assign done       = done_r;
  assign rd_we      = rd_we_r;
  assign rd_addr    = rd_addr_r;
  assign rd_data    = rd_data_r;
  assign misalign   = misalign_r;
  assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized traffic against a
// byte-level reference model of RV32I load/store semantics.
module tb_lsu;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_we, dmem_gnt, dmem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] alu_result, store_data, dmem_rdata;
  logic [4:0]  req_rd;
  logic        req_ready, busy, dmem_req, dmem_we, done, rd_we, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, rd_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  rd_addr;
  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .alu_result(alu_result),
    .store_data(store_data), .req_rd(req_rd), .busy(busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .done(done), .rd_we(rd_we), .rd_addr(rd_addr),
    .rd_data(rd_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f, input logic [31:0] a);
    int s = m_size(f);
    if (s == 0) return 1'b0;
    if (we && f[2]) return 1'b0;
    return (int'(a[1:0]) % s) == 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f, input logic [31:0] a);
    logic [3:0] r;
    int s = m_size(f);
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + s);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    logic [31:0] r;
    int s = m_size(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    longint v = 0;
    int s = m_size(f);
    int off = int'(a[1:0]);
    for (int k = 0; k < s; k++) v += longint'(w[8*(off+k) +: 8]) << (8*k);
    if (!f[2] && s < 4 && v >= (longint'(1) << (8*s-1))) v -= longint'(1) << (8*s);
    return 32'(v);
  endfunction

  // One access, starting and ending on a negedge. gd/rvd = cycles of gnt/rvalid delay.
  task automatic do_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] w);
    bit ok = m_legal(we, f, a);
    req_valid = 1'b1; req_we = we; req_funct3 = f; alu_result = a; store_data = sd; req_rd = rd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; alu_result = $urandom; store_data = $urandom;
    if (!ok) begin
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL bad_done got %b exp 1 f3=%b a=%h", done, f, a); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL bad_misalign got %b exp 1", misalign); end
      checks++; if (rd_we !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL bad_noaccess rd_we=%b dmem_req=%b exp 0 0", rd_we, dmem_req); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got %b exp 1", req_ready); end
      return;
    end
    checks++; if (done !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL req_state done=%b busy=%b ready=%b exp 0 1 0", done, busy, req_ready); end
    for (int c = 0; c <= gd; c++) begin
      checks++; if (dmem_req !== 1'b1 || dmem_we !== we || dmem_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL req_hold cyc%0d req=%b we=%b addr=%h exp 1 %b %h", c, dmem_req, dmem_we, dmem_addr, we, {a[31:2], 2'b00}); end
      checks++; if (dmem_wstrb !== (we ? m_wstrb(f, a) : 4'b0000)) begin errors++; $display("FAIL wstrb got %b exp %b", dmem_wstrb, we ? m_wstrb(f, a) : 4'b0000); end
      if (we) begin
        checks++; if (dmem_wdata !== m_wdata(f, sd)) begin errors++; $display("FAIL wdata got %h exp %h", dmem_wdata, m_wdata(f, sd)); end
      end
      checks++; if (done !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL early_done done=%b bus_err=%b exp 0 0", done, bus_err); end
      dmem_gnt = (c == gd);
      @(posedge clk); @(negedge clk);
    end
    dmem_gnt = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL req_drop got %b exp 0", dmem_req); end
    if (we) begin
      checks++; if (done !== 1'b1 || rd_we !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL st_done done=%b rd_we=%b mis=%b exp 1 0 0", done, rd_we, misalign); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL st_ready got %b exp 1", req_ready); end
      return;
    end
    for (int c = 0; c <= rvd; c++) begin
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_state done=%b busy=%b exp 0 1", done, busy); end
      dmem_rvalid = (c == rvd);
      dmem_rdata = (c == rvd) ? w : 32'($urandom);
      @(posedge clk); @(negedge clk);
    end
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    checks++; if (done !== 1'b1 || misalign !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL ld_done done=%b mis=%b berr=%b exp 1 0 0", done, misalign, bus_err); end
    checks++; if (rd_we !== (rd != 5'd0)) begin errors++; $display("FAIL ld_rd_we got %b exp %b", rd_we, rd != 5'd0); end
    checks++; if (rd_addr !== rd) begin errors++; $display("FAIL ld_rd_addr got %0d exp %0d", rd_addr, rd); end
    checks++; if (rd_data !== m_load(f, a, w)) begin errors++; $display("FAIL ld_data f3=%b a=%h w=%h got %h exp %h", f, a, w, rd_data, m_load(f, a, w)); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b exp 1", req_ready); end
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0 || rd_we !== 1'b0) begin errors++; $display("FAIL done_pulse done=%b rd_we=%b exp 0 0", done, rd_we); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_ready ready=%b busy=%b exp 1 0", req_ready, busy); end
    checks++; if ({dmem_req, dmem_we, done, rd_we, misalign, bus_err} !== 6'b0) begin errors++; $display("FAIL rst_pulses got %b exp 000000", {dmem_req, dmem_we, done, rd_we, misalign, bus_err}); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wstrb !== 4'h0 || rd_data !== 32'h0 || rd_addr !== 5'd0) begin errors++; $display("FAIL rst_data addr=%h strb=%h rdd=%h rda=%0d exp zeros", dmem_addr, dmem_wstrb, rd_data, rd_addr); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_store();
    do_op(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0);
    idle_cycle();
    do_op(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
    idle_cycle();
    do_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 5'd0, 1, 0, 32'h0);
    idle_cycle();
  endtask

  task automatic test_load();
    do_op(1'b0, 3'b000, 32'h0000_0302, 32'h0, 5'd5, 0, 0, 32'h1280_5634);
    idle_cycle();
    do_op(1'b0, 3'b101, 32'h0000_0302, 32'h0, 5'd7, 0, 0, 32'h1280_5634);
    idle_cycle();
    do_op(1'b0, 3'b001, 32'h0000_0500, 32'h0, 5'd0, 0, 1, 32'h0000_8001);
    idle_cycle();
  endtask

  task automatic test_misalign();
    do_op(1'b0, 3'b010, 32'h0000_0401, 32'h0, 5'd3, 0, 0, 32'h0);
    idle_cycle();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_noreq got %b exp 0", dmem_req); end
    do_op(1'b1, 3'b001, 32'h0000_0101, 32'h0, 5'd0, 0, 0, 32'h0);
    do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd1, 0, 0, 32'h0);
    do_op(1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd0, 0, 0, 32'h0);
    idle_cycle();
  endtask

  task automatic test_delayed();
    do_op(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd9, 3, 2, 32'hCAFE_F00D);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; alu_result = 32'h0000_0700; req_rd = 5'd4;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL midrst ready=%b busy=%b req=%b exp 1 0 0", req_ready, busy, dmem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    checks++; if (done !== 1'b0 || rd_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stray done=%b rd_we=%b ready=%b exp 0 0 1", done, rd_we, req_ready); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 3'b010, 32'h0000_0800, 32'h0102_0304, 5'd0, 0, 0, 32'h0);
    do_op(1'b0, 3'b100, 32'h0000_0803, 32'h0, 5'd12, 0, 0, 32'hF0E0_D0C0);
    do_op(1'b0, 3'b010, 32'h0000_0805, 32'h0, 5'd12, 0, 0, 32'h0);
    do_op(1'b0, 3'b001, 32'h0000_0806, 32'h0, 5'd31, 0, 0, 32'h9ABC_0000);
    idle_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      logic we = 1'($urandom);
      logic [2:0] f = 3'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(3, 0) != 0) a[1:0] = (f[1:0] == 2'b10) ? 2'b00 : (f[0] ? {1'($urandom), 1'b0} : a[1:0]);
      do_op(we, f, a, $urandom, 5'($urandom), $urandom_range(4, 0), $urandom_range(4, 0), $urandom);
      if ($urandom_range(1, 0) != 0) idle_cycle();
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int n = 1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; alu_result = 32'h0000_0900; req_rd = 5'd6;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (n !== TMO + 1) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", n, TMO + 1); end
    checks++; if (bus_err !== 1'b1 || rd_we !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL tmo_flags berr=%b rd_we=%b mis=%b exp 1 0 0", bus_err, rd_we, misalign); end
    checks++; if (req_ready !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL tmo_idle ready=%b req=%b exp 1 0", req_ready, dmem_req); end
    idle_cycle();
  endtask
`else
  task automatic test_long_stall();
    do_op(1'b0, 3'b010, 32'h0000_0A00, 32'h0, 5'd8, 25, 20, 32'h5555_AAAA);
    idle_cycle();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; alu_result = 32'h0;
    store_data = 32'h0; req_rd = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_delayed();
    test_reset_mid();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
